// File: rtl/ula_seq_if.sv
// Operand/result handshake bundle for ula_seq: producer-side request channel and
// consumer-side result channel, each with its own valid/ready pair.
interface ula_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/ula_seq.sv
// Handshaked sequential ALU with registered result and {err, ovf, carry, zero} flags.
// Define ULA_SEQ_MULDIV_EN to build the iterative multiply/divide datapath.
module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    ula_seq_if.slave   bus,
    output logic [1:0] dbg_state
);
    // Handshake: a side transfers on the rising edge where its valid and ready
    // are both 1; valid, once raised, is held with stable payload until that edge.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             accept;
    logic             start_multi;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_err;
    logic [WIDTH:0]   sum;

    assign accept        = bus.in_valid && (state_q == IDLE);
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign dbg_state     = state_q;
    assign sum           = {1'b0, bus.a} + {1'b0, bus.b};

`ifdef ULA_SEQ_MULDIV_EN
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rsh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_nx;
    logic               is_mul;

    assign start_multi = (bus.opcode == 4'h3) || ((bus.opcode == 4'h4) && (bus.b != '0));
    assign is_mul      = (op_q == 4'h3);

    // Multiply: acc = {partial, multiplier}; add A into the top half on lsb, shift right.
    // Divide:   acc = {remainder, dividend/quotient}; restoring shift-subtract.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        rsh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rsh - {1'b0, b_q};
        if (is_mul)
            acc_nx = {mul_sum, acc_q[WIDTH-1:1]};
        else if (diff[WIDTH])
            acc_nx = {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            acc_nx = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            op_q  <= bus.opcode;
            a_q   <= bus.a;
            b_q   <= bus.b;
            acc_q <= (bus.opcode == 4'h3) ? {{WIDTH{1'b0}}, bus.b} : {{WIDTH{1'b0}}, bus.a};
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            acc_q <= acc_nx;
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign start_multi = 1'b0;
`endif

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        case (bus.opcode)
            4'h0: sc_res = '0;
            4'h1: {sc_carry, sc_res} = sum;
            4'h2: begin
                sc_res   = bus.a - bus.b;
                sc_carry = (bus.a < bus.b);
            end
`ifdef ULA_SEQ_MULDIV_EN
            4'h3: sc_res = '0;
            4'h4: begin
                sc_res = '1;
                sc_err = 1'b1;
            end
`else
            4'h3, 4'h4: sc_err = 1'b1;
`endif
            4'h5: sc_res = bus.a & bus.b;
            4'h6: sc_res = bus.a | bus.b;
            4'h7: sc_res = ~bus.a;
            4'h8: sc_res = bus.a ^ bus.b;
            4'h9: sc_res = bus.a ~^ bus.b;
            4'hA: sc_res = bus.a;
            4'hB: sc_res = ~bus.a;
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = start_multi ? BUSY : DONE;
`ifdef ULA_SEQ_MULDIV_EN
            BUSY: if (cnt_q == LAST) state_d = DONE;
`endif
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept && !start_multi) begin
                result_q <= sc_res;
                flags_q  <= {sc_err, 1'b0, sc_carry, ~|sc_res};
            end
`ifdef ULA_SEQ_MULDIV_EN
            else if ((state_q == BUSY) && (cnt_q == LAST)) begin
                result_q <= acc_nx[WIDTH-1:0];
                flags_q  <= {1'b0, is_mul && (|acc_nx[2*WIDTH-1:WIDTH]), 1'b0,
                             ~|acc_nx[WIDTH-1:0]};
            end
`endif
        end
    end
endmodule
